router_node_port: RTL and testbench



---
 rtl/router_node_port_pkg.sv | 25 ++
 rtl/router_node_port_fifo.sv | 63 ++++++
 rtl/router_node_port.sv | 192 +++++++++++++++++++
 tb/tb_router_node_port.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_node_port_pkg.sv
// Shared types for the router-side node port: packet type, burst length, TX FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_node_port_pkg;

    localparam int BYTES_PER_PKT = 4;
    localparam int PKT_W         = 8 * BYTES_PER_PKT;

    // 32-bit packet as carried over the node<->router link, byte0 in [31:24]
    typedef logic [PKT_W-1:0] pkt_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_B0,
        TX_B1,
        TX_B2,
        TX_B3
    } tx_state_t;

    // Most-significant byte of a packet: the next byte to go on the wire
    function automatic logic [7:0] msb_byte(input pkt_t p);
        return p[PKT_W-1 -: 8];
    endfunction

endpackage

// File: rtl/router_node_port_fifo.sv
// Packet FIFO for the inbound path; combinational head read, push/pop with occupancy count.
// Latency: a pushed entry is visible at the head (count != 0) the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens on the same edge.
// Ports: clock/reset, push + push_data, pop, head (entry at read pointer), count (occupancy).
module port_fifo
    import router_node_port_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
)(
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  pkt_t          push_data,
    input  logic          pop,
    output pkt_t          head,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pkt_t          mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // Push at full is allowed only when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_node_port.sv
// Router-side endpoint of the byte-serial node link: RX burst reassembly into a FIFO, TX packet serializer.
// Latency: RX packet valid the cycle after its 4th byte edge; TX byte0 on the wire 2 edges after accept (node_free=1).
// Backpressure: router_free throttles the node per packet; tx_ready drops while the TX holding register is full.
// Ports: node link (node_put/node_payload in, router_put/router_payload out, router_free out, node_free in),
//        crossbar RX (rx_pkt/rx_valid out, rx_ready in), crossbar TX (tx_pkt/tx_valid in, tx_ready out).
// Optional: define ROUTER_PORT_STATS_EN to add rx_pkt_count, tx_pkt_count and sticky proto_err outputs.
module router_node_port
    import router_node_port_pkg::*;
#(
    parameter int RX_DEPTH = 2
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        node_put,
    input  logic [7:0]  node_payload,
    output logic        router_free,
    output logic        router_put,
    output logic [7:0]  router_payload,
    input  logic        node_free,
    output pkt_t        rx_pkt,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  pkt_t        tx_pkt,
    input  logic        tx_valid,
    output logic        tx_ready
`ifdef ROUTER_PORT_STATS_EN
    ,
    output logic [15:0] rx_pkt_count,
    output logic [15:0] tx_pkt_count,
    output logic        proto_err
`endif
);

    localparam int CW = $clog2(RX_DEPTH + 1);

    // ------------------------------------------------------------------
    // RX: byte assembly
    // ------------------------------------------------------------------
    logic [1:0]    rx_cnt;
    logic [1:0]    rx_cnt_next;
    logic [7:0]    asm_b0;
    logic [7:0]    asm_b1;
    logic [7:0]    asm_b2;
    logic          rx_busy;
    logic          rx_accept;
    logic          rx_drop;
    logic          rx_push;
    logic          rx_pop;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] occ_next;
    pkt_t          rx_asm_pkt;

    assign rx_busy     = (rx_cnt != 2'd0);
    // Mid-burst bytes are always taken; a new burst needs router_free
    assign rx_accept   = node_put && (rx_busy || router_free);
    assign rx_drop     = node_put && !rx_busy && !router_free;
    assign rx_push     = rx_accept && (rx_cnt == 2'd3);
    assign rx_pop      = rx_valid && rx_ready;
    assign rx_cnt_next = rx_accept ? rx_cnt + 2'd1 : rx_cnt;
    assign occ_next    = rx_count + CW'(rx_push) - CW'(rx_pop);
    assign rx_asm_pkt  = {asm_b0, asm_b1, asm_b2, node_payload};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_cnt      <= 2'd0;
            asm_b0      <= 8'd0;
            asm_b1      <= 8'd0;
            asm_b2      <= 8'd0;
            router_free <= 1'b1;
        end else begin
            rx_cnt <= rx_cnt_next;
            if (rx_accept) begin
                case (rx_cnt)
                    2'd0:    asm_b0 <= node_payload;
                    2'd1:    asm_b1 <= node_payload;
                    2'd2:    asm_b2 <= node_payload;
                    default: ; // byte3 goes straight into the FIFO
                endcase
            end
            // Free only between bursts and only if a whole packet still fits
            router_free <= (rx_cnt_next == 2'd0) && (occ_next < CW'(RX_DEPTH));
        end
    end

    port_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_asm_pkt),
        .pop       (rx_pop),
        .head      (rx_pkt),
        .count     (rx_count)
    );

    assign rx_valid = (rx_count != '0);

    // ------------------------------------------------------------------
    // TX: holding register
    // ------------------------------------------------------------------
    pkt_t      hold_q;
    logic      hold_full;
    logic      tx_load;
    logic      tx_take;
    tx_state_t tx_state;
    pkt_t      shift_q;

    assign tx_ready = !hold_full;
    assign tx_load  = tx_valid && tx_ready;
    assign tx_take  = (tx_state == TX_IDLE) && hold_full && node_free;

    // tx_load and tx_take never coincide: loading needs the register empty
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (tx_load) begin
            hold_q    <= tx_pkt;
            hold_full <= 1'b1;
        end else if (tx_take) begin
            hold_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // TX: serializer FSM; each Bn state drives byte n onto the wire at its
    // exit edge, so the wire lags the state by one cycle and the IDLE visit
    // between bursts leaves one dead cycle on the link.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state       <= TX_IDLE;
            shift_q        <= '0;
            router_put     <= 1'b0;
            router_payload <= 8'd0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    router_put     <= 1'b0;
                    router_payload <= 8'd0;
                    if (tx_take) begin
                        shift_q  <= hold_q;
                        tx_state <= TX_B0;
                    end
                end
                TX_B0, TX_B1, TX_B2, TX_B3: begin
                    router_put     <= 1'b1;
                    router_payload <= msb_byte(shift_q);
                    shift_q        <= shift_q << 8;
                    case (tx_state)
                        TX_B0:   tx_state <= TX_B1;
                        TX_B1:   tx_state <= TX_B2;
                        TX_B2:   tx_state <= TX_B3;
                        default: tx_state <= TX_IDLE;
                    endcase
                end
                default: begin
                    tx_state   <= TX_IDLE;
                    router_put <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROUTER_PORT_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: wrapping packet counters and sticky protocol error
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_pkt_count <= 16'd0;
            tx_pkt_count <= 16'd0;
            proto_err    <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_pkt_count <= rx_pkt_count + 16'd1;
            end
            if (tx_state == TX_B3) begin
                tx_pkt_count <= tx_pkt_count + 16'd1;
            end
            if (rx_drop) begin
                proto_err <= 1'b1;
            end
        end
    end
`else
    logic unused_drop;
    assign unused_drop = rx_drop;
`endif

endmodule

// File: tb/tb_router_node_port.sv
module tb_router_node_port;
    import router_node_port_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        node_put;
    logic [7:0]  node_payload;
    logic        router_free;
    logic        router_put;
    logic [7:0]  router_payload;
    logic        node_free;
    pkt_t        rx_pkt;
    logic        rx_valid;
    logic        rx_ready;
    pkt_t        tx_pkt;
    logic        tx_valid;
    logic        tx_ready;
`ifdef ROUTER_PORT_STATS_EN
    logic [15:0] rx_pkt_count;
    logic [15:0] tx_pkt_count;
    logic        proto_err;
`endif

    always #5 clock = ~clock;

    router_node_port #(.RX_DEPTH(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .node_put       (node_put),
        .node_payload   (node_payload),
        .router_free    (router_free),
        .router_put     (router_put),
        .router_payload (router_payload),
        .node_free      (node_free),
        .rx_pkt         (rx_pkt),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_pkt         (tx_pkt),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
`ifdef ROUTER_PORT_STATS_EN
        ,
        .rx_pkt_count   (rx_pkt_count),
        .tx_pkt_count   (tx_pkt_count),
        .proto_err      (proto_err)
`endif
    );

    typedef struct {
        logic [3:0][7:0] bytes;   // bytes[3] goes first on the wire
        logic [31:0]     exp_pkt;
    } rx_vec_t;

    typedef struct {
        logic [31:0]     pkt;
        logic [3:0][7:0] exp_bytes; // exp_bytes[3] expected first
    } tx_vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rxq[$];
    logic [7:0]  txq[$];
    int          tx_run = 0;
    logic        put_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: samples on the falling edge
    always @(negedge clock) begin
        if (reset) begin
            put_prev = 1'b0;
            tx_run   = 0;
        end else begin
            if (rx_valid && rx_ready) begin
                if (rxq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %h expected no packet", rx_pkt);
                end else begin
                    chk("rx_pkt", rx_pkt, rxq.pop_front());
                end
            end
            if (router_put) begin
                tx_run++;
                if (txq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %h expected no byte", router_payload);
                end else begin
                    chk("tx_byte", {24'd0, router_payload}, {24'd0, txq.pop_front()});
                end
            end else if (put_prev) begin
                chk("tx_burst_len", tx_run, 32'd4);
                tx_run = 0;
            end
            put_prev = router_put;
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_router_free"},    {31'd0, router_free},    32'd1);
        chk({tag, "_router_put"},     {31'd0, router_put},     32'd0);
        chk({tag, "_router_payload"}, {24'd0, router_payload}, 32'd0);
        chk({tag, "_rx_valid"},       {31'd0, rx_valid},       32'd0);
        chk({tag, "_tx_ready"},       {31'd0, tx_ready},       32'd1);
    endtask

    task automatic send_rx(input logic [3:0][7:0] b, input logic [31:0] exp);
        int n;
        n = 0;
        while (!router_free && n < 100) begin
            tick();
            n++;
        end
        chk("rx_wait_free_timeout", n >= 100, 32'd0);
        for (int i = 3; i >= 0; i--) begin
            node_put     = 1'b1;
            node_payload = b[i];
            if (i == 0) rxq.push_back(exp);
            tick();
        end
        node_put = 1'b0;
    endtask

    task automatic send_tx(input logic [31:0] p, input logic [3:0][7:0] eb);
        int n;
        n = 0;
        while (!tx_ready && n < 100) begin
            tick();
            n++;
        end
        chk("tx_wait_ready_timeout", n >= 100, 32'd0);
        tx_pkt   = p;
        tx_valid = 1'b1;
        for (int i = 3; i >= 0; i--) txq.push_back(eb[i]);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((rxq.size() != 0 || txq.size() != 0 || router_put) && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_drain_timeout"}, n >= 300, 32'd0);
        tick();
    endtask

    rx_vec_t rx_tab[4];
    tx_vec_t tx_tab[4];

    initial begin
        rx_tab[0] = '{bytes: 32'hDEADBEEF, exp_pkt: 32'hDEADBEEF};
        rx_tab[1] = '{bytes: 32'h00FF00FF, exp_pkt: 32'h00FF00FF};
        rx_tab[2] = '{bytes: 32'h12345678, exp_pkt: 32'h12345678};
        rx_tab[3] = '{bytes: 32'hA5C3E187, exp_pkt: 32'hA5C3E187};
        tx_tab[0] = '{pkt: 32'h01020304, exp_bytes: {8'h01, 8'h02, 8'h03, 8'h04}};
        tx_tab[1] = '{pkt: 32'hA1B2C3D4, exp_bytes: {8'hA1, 8'hB2, 8'hC3, 8'hD4}};
        tx_tab[2] = '{pkt: 32'hFF00AA55, exp_bytes: {8'hFF, 8'h00, 8'hAA, 8'h55}};
        tx_tab[3] = '{pkt: 32'h80000001, exp_bytes: {8'h80, 8'h00, 8'h00, 8'h01}};

        reset        = 1'b1;
        node_put     = 1'b0;
        node_payload = 8'd0;
        rx_ready     = 1'b0;
        tx_pkt       = '0;
        tx_valid     = 1'b0;
        node_free    = 1'b1;
        repeat (2) tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        // Single burst DE AD BE EF with router_free tracked per edge
        rx_ready = 1'b1;
        chk("free_before_burst", {31'd0, router_free}, 32'd1);
        for (int i = 3; i >= 0; i--) begin
            node_put     = 1'b1;
            node_payload = rx_tab[0].bytes[i];
            if (i == 0) rxq.push_back(rx_tab[0].exp_pkt);
            tick();
            if (i > 0) chk("free_mid_burst", {31'd0, router_free}, 32'd0);
        end
        node_put = 1'b0;
        chk("free_after_push", {31'd0, router_free}, 32'd1);
        chk("rx_valid_after_push", {31'd0, rx_valid}, 32'd1);
        tick();
        chk("rx_valid_after_pop", {31'd0, rx_valid}, 32'd0);

        // Table-driven back-to-back bursts with the crossbar always ready
        for (int i = 1; i < 4; i++) send_rx(rx_tab[i].bytes, rx_tab[i].exp_pkt);
        drain("rx_table");

        // FIFO full: two bursts with no pop, then a dropped byte
        rx_ready = 1'b0;
        send_rx(rx_tab[2].bytes, rx_tab[2].exp_pkt);
        send_rx(rx_tab[3].bytes, rx_tab[3].exp_pkt);
        chk("full_free", {31'd0, router_free}, 32'd0);
        chk("full_head", rx_pkt, 32'h12345678);
        node_put     = 1'b1;
        node_payload = 8'h55;
        tick();
        node_put = 1'b0;
        tick();
        chk("drop_free", {31'd0, router_free}, 32'd0);
        chk("drop_head", rx_pkt, 32'h12345678);
        chk("drop_valid", {31'd0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        tick();
        chk("free_after_pop", {31'd0, router_free}, 32'd1);
        chk("head_after_pop", rx_pkt, 32'hA5C3E187);
        tick();
        chk("empty_after_pops", {31'd0, rx_valid}, 32'd0);
        send_rx(rx_tab[1].bytes, rx_tab[1].exp_pkt);
        drain("after_drop");

        // TX latency: accept edge, FSM leaves IDLE, then byte0 on the wire
        node_free = 1'b1;
        chk("tx_ready_idle", {31'd0, tx_ready}, 32'd1);
        send_tx(tx_tab[0].pkt, tx_tab[0].exp_bytes);
        chk("tx_ready_held", {31'd0, tx_ready}, 32'd0);
        chk("tx_put_e0", {31'd0, router_put}, 32'd0);
        tick();
        chk("tx_ready_reassert", {31'd0, tx_ready}, 32'd1);
        chk("tx_put_e1", {31'd0, router_put}, 32'd0);
        tick();
        chk("tx_put_e2", {31'd0, router_put}, 32'd1);
        chk("tx_byte0_e2", {24'd0, router_payload}, 32'h01);
        drain("tx_single");

        // node_free low blocks the burst while the packet is held
        node_free = 1'b0;
        send_tx(tx_tab[1].pkt, tx_tab[1].exp_bytes);
        repeat (3) tick();
        chk("blocked_put", {31'd0, router_put}, 32'd0);
        chk("blocked_tx_ready", {31'd0, tx_ready}, 32'd0);
        node_free = 1'b1;
        tick();
        chk("unblocked_tx_ready", {31'd0, tx_ready}, 32'd1);
        tick();
        chk("unblocked_put", {31'd0, router_put}, 32'd1);
        chk("unblocked_byte0", {24'd0, router_payload}, 32'hA1);
        drain("tx_blocked");

        // Back-to-back crossbar packets: burst length check catches a missing gap
        for (int i = 2; i < 4; i++) send_tx(tx_tab[i].pkt, tx_tab[i].exp_bytes);
        send_tx(tx_tab[0].pkt, tx_tab[0].exp_bytes);
        drain("tx_b2b");

        // Reset after RX byte1 and while TX is in B2
        send_tx(32'hF1F2F3F4, {8'hF1, 8'hF2, 8'hF3, 8'hF4});
        tick();
        node_put     = 1'b1;
        node_payload = 8'h11;
        tick();
        node_payload = 8'h22;
        tick();
        node_put = 1'b0;
        reset    = 1'b1;
        #1;
        check_reset_values("midreset");
        txq.delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        send_rx(rx_tab[2].bytes, rx_tab[2].exp_pkt);
        send_tx(tx_tab[1].pkt, tx_tab[1].exp_bytes);
        drain("post_reset");

        chk("rxq_left", rxq.size(), 32'd0);
        chk("txq_left", txq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
